// File: rtl/vga_raster.sv
// vga_raster: 640x480@60Hz VGA timing plus Tetris board, frame and
// next-piece preview renderer, two 50 MHz clocks per pixel.
//
// Ports:
//   clk        50 MHz system clock
//   rst        synchronous reset, active-low
//   enable     1 = colour on; 0 = RGB forced to 000, syncs keep running
//   clear      1 = counters held at 0, outputs at reset values
//   tiles      200 tile bytes, row-major, byte 0 in bits [0:7], MSB first
//   next_tile  16 preview bytes, same packing, 4x4 grid
//   hcnt       horizontal clock counter, 0..1599
//   vcnt       line counter, 0..524
//   vga_HS     horizontal sync, active-low
//   vga_VS     vertical sync, active-low
//   vga_R/G/B  1-bit colour outputs
module vga_raster (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          clear,
   input  logic [0:1599] tiles,
   input  logic [0:127]  next_tile,
   output logic [10:0]   hcnt,
   output logic [9:0]    vcnt,
   output logic          vga_HS,
   output logic          vga_VS,
   output logic          vga_R,
   output logic          vga_G,
   output logic          vga_B
);

   localparam logic [10:0] H_LAST  = 11'd1599;
   localparam logic [9:0]  V_LAST  = 10'd524;

   // Sync windows in clock/line units; end is exclusive.
   localparam logic [10:0] HS_BEG  = 11'd1312;
   localparam logic [10:0] HS_END  = 11'd1504;
   localparam logic [9:0]  VS_BEG  = 10'd490;
   localparam logic [9:0]  VS_END  = 10'd492;

   localparam logic [9:0]  H_VIS   = 10'd640;
   localparam logic [9:0]  V_VIS   = 10'd480;

   localparam logic [9:0]  BOARD_X = 10'd240;
   localparam logic [9:0]  BOARD_Y = 10'd80;
   localparam logic [9:0]  BOARD_R = 10'd400;
   localparam logic [9:0]  BOARD_B = 10'd400;

   localparam logic [9:0]  FRM_L   = 10'd232;
   localparam logic [9:0]  FRM_R   = 10'd408;
   localparam logic [9:0]  FRM_T   = 10'd72;
   localparam logic [9:0]  FRM_B   = 10'd408;

   localparam logic [9:0]  NEXT_X  = 10'd448;
   localparam logic [9:0]  NEXT_Y  = 10'd80;
   localparam logic [9:0]  NEXT_R  = 10'd512;
   localparam logic [9:0]  NEXT_B  = 10'd144;

   logic [10:0] hcnt_q, hcnt_d;
   logic [9:0]  vcnt_q, vcnt_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic [2:0]  rgb_q, rgb_d;

   logic [9:0]  x;
   logic [9:0]  y;
   logic        vis;
   logic        in_board;
   logic        in_frame;
   logic        in_next;

   logic [7:0]  bx;
   logic [8:0]  by;
   logic [7:0]  tidx;
   logic [2:0]  tile_rgb;
   logic        tile_gap;

   logic [5:0]  nx;
   logic [5:0]  ny;
   logic [3:0]  nidx;
   logic [2:0]  next_rgb;
   logic        next_gap;

   logic [2:0]  pix;

   // ---------------------------------------------------------------
   // Counters
   // ---------------------------------------------------------------
   always_comb begin
      hcnt_d = hcnt_q + 11'd1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = 11'd0;
         if (vcnt_q == V_LAST) begin
            vcnt_d = 10'd0;
         end else begin
            vcnt_d = vcnt_q + 10'd1;
         end
      end
      if (clear) begin
         hcnt_d = 11'd0;
         vcnt_d = 10'd0;
      end
   end

   // ---------------------------------------------------------------
   // Region decode on the current counter value
   // ---------------------------------------------------------------
   always_comb begin
      x = hcnt_q[10:1];
      y = vcnt_q;

      vis = (x < H_VIS) && (y < V_VIS);

      in_board = (x >= BOARD_X) && (x < BOARD_R) &&
                 (y >= BOARD_Y) && (y < BOARD_B);

      in_frame = (x >= FRM_L) && (x < FRM_R) &&
                 (y >= FRM_T) && (y < FRM_B) && !in_board;

      in_next  = (x >= NEXT_X) && (x < NEXT_R) &&
                 (y >= NEXT_Y) && (y < NEXT_B);
   end

   // ---------------------------------------------------------------
   // Board cell lookup
   // ---------------------------------------------------------------
   // Offsets only need enough bits to span the board; the modular
   // subtraction is exact whenever in_board is set.
   always_comb begin
      bx = x[7:0] - BOARD_X[7:0];
      by = y[8:0] - BOARD_Y[8:0];

      tidx = 8'd0;
      if (in_board) begin
         tidx = {3'b000, by[8:4]} * 8'd10 + {4'b0000, bx[7:4]};
      end

      // Bits 5..7 of each MSB-first byte carry R,G,B.
      tile_rgb = tiles[({tidx, 3'b000} + 11'd5) +: 3];
      tile_gap = (bx[3:0] == 4'hf) || (by[3:0] == 4'hf);
   end

   // ---------------------------------------------------------------
   // Preview cell lookup
   // ---------------------------------------------------------------
   always_comb begin
      nx = x[5:0] - NEXT_X[5:0];
      ny = y[5:0] - NEXT_Y[5:0];

      nidx = 4'd0;
      if (in_next) begin
         nidx = {ny[5:4], nx[5:4]};
      end

      next_rgb = next_tile[({nidx, 3'b000} + 7'd5) +: 3];
      next_gap = (nx[3:0] == 4'hf) || (ny[3:0] == 4'hf);
   end

   // ---------------------------------------------------------------
   // Colour select and sync, one register stage after the counters
   // ---------------------------------------------------------------
   always_comb begin
      pix = 3'b000;
      unique case (1'b1)
         in_board: pix = tile_gap ? 3'b000 : tile_rgb;
         in_frame: pix = 3'b111;
         in_next:  pix = next_gap ? 3'b000 : next_rgb;
         default:  pix = 3'b000;
      endcase

      rgb_d = (vis && enable) ? pix : 3'b000;
      hs_d  = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
      vs_d  = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));

      if (clear) begin
         rgb_d = 3'b000;
         hs_d  = 1'b1;
         vs_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hcnt_q <= 11'd0;
         vcnt_q <= 10'd0;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         rgb_q  <= 3'b000;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         rgb_q  <= rgb_d;
      end
   end

   assign hcnt   = hcnt_q;
   assign vcnt   = vcnt_q;
   assign vga_HS = hs_q;
   assign vga_VS = vs_q;
   assign vga_R  = rgb_q[2];
   assign vga_G  = rgb_q[1];
   assign vga_B  = rgb_q[0];

endmodule

// File: tb/tb_vga_raster.sv
// tb_vga_raster: directed single-frame sweep of vga_raster.
// Pixel (x,y) colour is sampled when hcnt = 2x+1 on line y.
module tb_vga_raster;

   logic          clk;
   logic          rst;
   logic          enable;
   logic          clear;
   logic [0:1599] tiles;
   logic [0:127]  next_tile;
   logic [10:0]   hcnt;
   logic [9:0]    vcnt;
   logic          vga_HS;
   logic          vga_VS;
   logic          vga_R;
   logic          vga_G;
   logic          vga_B;

   int          n_chk = 0;
   int          n_err = 0;
   int unsigned cyc   = 0;
   int unsigned t0    = 0;

   vga_raster dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .clear     (clear),
      .tiles     (tiles),
      .next_tile (next_tile),
      .hcnt      (hcnt),
      .vcnt      (vcnt),
      .vga_HS    (vga_HS),
      .vga_VS    (vga_VS),
      .vga_R     (vga_R),
      .vga_G     (vga_G),
      .vga_B     (vga_B)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic goto(input int h, input int v);
      int n;
      n = 0;
      while (!(hcnt == 11'(h) && vcnt == 10'(v)) && n < 850000) begin
         tick(1);
         n++;
      end
      if (n >= 850000) check("timeout", 32'(hcnt), 32'(h));
   endtask

   task automatic px(input string tag, input int xx, input int yy,
                     input logic [2:0] exp);
      goto(2 * xx + 1, yy);
      check(tag, {29'd0, vga_R, vga_G, vga_B}, {29'd0, exp});
   endtask

   initial begin
      rst       = 1'b0;
      enable    = 1'b1;
      clear     = 1'b0;
      tiles     = '0;
      next_tile = '0;
      tiles[0:7]       = 8'h04;
      tiles[1592:1599] = 8'h07;
      next_tile[40:47] = 8'h02;

      tick(5);
      check("rst_h",   32'(hcnt), 32'd0);
      check("rst_v",   32'(vcnt), 32'd0);
      check("rst_hs",  32'(vga_HS), 32'd1);
      check("rst_vs",  32'(vga_VS), 32'd1);
      check("rst_rgb", {29'd0, vga_R, vga_G, vga_B}, 32'd0);

      rst = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         check("run_h", 32'(hcnt), 32'(i));
      end

      clear = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("clr_h",  32'(hcnt), 32'd0);
         check("clr_hs", 32'(vga_HS), 32'd1);
      end
      clear = 1'b0;
      tick(1);
      check("clr_run", 32'(hcnt), 32'd1);
      t0 = cyc;

      goto(1312, 0);
      check("hs_pre", 32'(vga_HS), 32'd1);
      tick(1);
      check("hs_low", 32'(vga_HS), 32'd0);
      goto(1504, 0);
      check("hs_end", 32'(vga_HS), 32'd0);
      tick(1);
      check("hs_post", 32'(vga_HS), 32'd1);

      goto(1599, 0);
      tick(1);
      check("wrap_h", 32'(hcnt), 32'd0);
      check("wrap_v", 32'(vcnt), 32'd1);

      px("frm_out", 231, 72, 3'b000);
      px("frm_in",  232, 72, 3'b111);

      px("brd_red", 240, 80, 3'b100);
      tick(1);
      check("en_pre", {29'd0, vga_R, vga_G, vga_B}, 32'd4);
      enable = 1'b0;
      tick(1);
      check("en_off", {29'd0, vga_R, vga_G, vga_B}, 32'd0);
      goto(1312, 80);
      check("en_hs1", 32'(vga_HS), 32'd1);
      tick(1);
      check("en_hs0", 32'(vga_HS), 32'd0);
      enable = 1'b1;

      px("brd_red2", 254, 81, 3'b100);
      px("brd_gap",  255, 81, 3'b000);
      px("prev",     464, 96, 3'b010);
      px("hblank",   700, 100, 3'b000);

      px("gap_x",    383, 384, 3'b000);
      px("brd_wht",  384, 384, 3'b111);
      px("brd_wht2", 385, 398, 3'b111);
      px("gap_y",    384, 399, 3'b000);
      px("frm_bot",  300, 405, 3'b111);
      px("frm_below", 300, 408, 3'b000);
      px("vblank",   300, 480, 3'b000);

      goto(0, 490);
      check("vs_pre", 32'(vga_VS), 32'd1);
      tick(1);
      check("vs_low", 32'(vga_VS), 32'd0);
      goto(800, 491);
      check("vs_mid", 32'(vga_VS), 32'd0);
      goto(0, 492);
      check("vs_end", 32'(vga_VS), 32'd0);
      tick(1);
      check("vs_post", 32'(vga_VS), 32'd1);

      goto(1599, 524);
      tick(1);
      check("fwrap_h", 32'(hcnt), 32'd0);
      check("fwrap_v", 32'(vcnt), 32'd0);
      check("frame_len", cyc - t0, 32'd839999);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
